// File: rtl/ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
// Shared types and constants for the nibble-serial ALU sequencer.
//   seq_state_t      : sequencer FSM states
//   NIB_W            : width of one ALU slice
//   S_SUB_LO/S_SUB_HI: arithmetic function codes whose slice carry-out is
//                      reported inverted (subtract family)
//   carry_inverted() : 1 when the slice carry-out must be inverted to get
//                      the true carry into the next nibble
// ---------------------------------------------------------------------------
package ula_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

   localparam int NIB_W = 4;

   localparam logic [3:0] S_SUB_LO = 4'b1000;
   localparam logic [3:0] S_SUB_HI = 4'b1011;

   function automatic logic carry_inverted(input logic m, input logic [3:0] s);
      return (!m) && (s >= S_SUB_LO) && (s <= S_SUB_HI);
   endfunction

endpackage

// File: rtl/ula_nibble_seq.sv
// ---------------------------------------------------------------------------
// ula_nibble_seq
// Runs a W = 4*NIBBLES bit operation through an external combinational 4-bit
// ALU slice, one nibble per clock, LS nibble first, and assembles a
// registered wide result.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operation request handshake
//   in_a, in_b [W]        : operands
//   in_s [4], in_m, in_cin: function select, logic mode, carry-in of nibble 0
//   alu_a/alu_b/alu_s/alu_m/alu_cin : registered drive to the ALU slice
//   alu_f/alu_cout/alu_aeqb         : ALU slice results (same cycle)
//   out_valid/out_ready   : result handshake
//   res [W]               : assembled result
//   c_out                 : raw carry-out of the last nibble
//   a_eq_b                : AND of alu_aeqb over all nibbles
//   zero, neg             : result flags, only with ULA_NIBBLE_SEQ_FLAGS_EN
//
// Build option: define ULA_NIBBLE_SEQ_FLAGS_EN to add the zero/neg outputs.
// ---------------------------------------------------------------------------
module ula_nibble_seq
   import ula_pkg::*;
#(
   parameter  int NIBBLES = 4,
   localparam int W       = NIB_W * NIBBLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [3:0]       in_s,
   input  logic             in_m,
   input  logic             in_cin,
   output logic [NIB_W-1:0] alu_a,
   output logic [NIB_W-1:0] alu_b,
   output logic [3:0]       alu_s,
   output logic             alu_m,
   output logic             alu_cin,
   input  logic [NIB_W-1:0] alu_f,
   input  logic             alu_cout,
   input  logic             alu_aeqb,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef ULA_NIBBLE_SEQ_FLAGS_EN
   output logic             zero,
   output logic             neg,
`endif
   output logic [W-1:0]     res,
   output logic             c_out,
   output logic             a_eq_b
);

   localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

   seq_state_t    state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [3:0]    s_q, s_d;
   logic          m_q, m_d;
   logic          carry_q, carry_d;
   logic [W-1:0]  res_q, res_d;
   logic          cout_q, cout_d;
   logic          acc_q, acc_d;     // running a_eq_b over nibbles seen so far
   logic          aeqb_q, aeqb_d;
   logic          zero_q, zero_d;
   logic          neg_q, neg_d;

   logic          last_nib;

   assign last_nib = (k_q == K_LAST);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid)  state_d = RUN;
         RUN:     if (last_nib)  state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      k_d     = k_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      m_d     = m_q;
      carry_d = carry_q;
      res_d   = res_q;
      cout_d  = cout_q;
      acc_d   = acc_q;
      aeqb_d  = aeqb_q;
      zero_d  = zero_q;
      neg_d   = neg_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               s_d     = in_s;
               m_d     = in_m;
               carry_d = in_cin;
               k_d     = '0;
               acc_d   = 1'b1;
            end
         end
         RUN: begin
            res_d[k_q*NIB_W +: NIB_W] = alu_f;
            acc_d   = acc_q & alu_aeqb;
            // Subtract-family codes report an inverted carry; restore the
            // true carry before it feeds the next nibble.
            carry_d = alu_cout ^ carry_inverted(m_q, s_q);
            if (last_nib) begin
               k_d    = '0;          // k stays within 0..NIBBLES-1
               cout_d = alu_cout;    // raw, as the slice reports it
               aeqb_d = acc_q & alu_aeqb;
               zero_d = (res_d == '0);
               neg_d  = res_d[W-1];
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         default: ;                  // DONE: everything held
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         m_q     <= 1'b0;
         carry_q <= 1'b0;
         res_q   <= '0;
         cout_q  <= 1'b0;
         acc_q   <= 1'b0;
         aeqb_q  <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
      end else begin
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         m_q     <= m_d;
         carry_q <= carry_d;
         res_q   <= res_d;
         cout_q  <= cout_d;
         acc_q   <= acc_d;
         aeqb_q  <= aeqb_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
      end
   end

   // ---------------- outputs ----------------
   // Handshake outputs are pure state decodes: no input-to-output path.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);

   assign alu_a   = a_q[k_q*NIB_W +: NIB_W];
   assign alu_b   = b_q[k_q*NIB_W +: NIB_W];
   assign alu_s   = s_q;
   assign alu_m   = m_q;
   assign alu_cin = carry_q;

   assign res    = res_q;
   assign c_out  = cout_q;
   assign a_eq_b = aeqb_q;

`ifdef ULA_NIBBLE_SEQ_FLAGS_EN
   assign zero = zero_q;
   assign neg  = neg_q;
`else
   // Flag registers exist but have no consumer in this build.
   logic unused_flags;
   assign unused_flags = zero_q ^ neg_q;
`endif

endmodule

// File: tb/tb_ula_nibble_seq.sv
// ---------------------------------------------------------------------------
// tb_ula_nibble_seq
// Directed, table-driven bench for ula_nibble_seq (NIBBLES = 4) with a
// reference 4-bit ALU slice modelled inline. Expected values are hand
// computed. Hand-written sequences cover DONE back-pressure and reset
// during RUN.
// ---------------------------------------------------------------------------
module tb_ula_nibble_seq;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready;
   logic [W-1:0] in_a, in_b;
   logic [3:0]   in_s;
   logic         in_m, in_cin;
   logic [3:0]   alu_a, alu_b, alu_s, alu_f;
   logic         alu_m, alu_cin, alu_cout, alu_aeqb;
   logic         out_valid, out_ready;
   logic [W-1:0] res;
   logic         c_out, a_eq_b;
`ifdef ULA_NIBBLE_SEQ_FLAGS_EN
   logic         zero, neg;
`endif

   always #5 clk = ~clk;

   ula_nibble_seq #(.NIBBLES(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_s      (in_s),
      .in_m      (in_m),
      .in_cin    (in_cin),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_s     (alu_s),
      .alu_m     (alu_m),
      .alu_cin   (alu_cin),
      .alu_f     (alu_f),
      .alu_cout  (alu_cout),
      .alu_aeqb  (alu_aeqb),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef ULA_NIBBLE_SEQ_FLAGS_EN
      .zero      (zero),
      .neg       (neg),
`endif
      .res       (res),
      .c_out     (c_out),
      .a_eq_b    (a_eq_b)
   );

   // Reference ALU slice. Subtract family (m=0, s=1000..1011) computes
   // A + ~B + cin and reports the inverted carry; s=1111 is A - 1 + cin.
   logic [4:0] alu_sum;
   always_comb begin
      alu_sum  = '0;
      alu_f    = '0;
      alu_cout = 1'b0;
      alu_aeqb = (alu_a == alu_b);
      if (alu_m) begin
         case (alu_s)
            4'b0000: alu_f = ~alu_a;
            4'b0110: alu_f = alu_a ^ alu_b;
            4'b1011: alu_f = alu_a & alu_b;
            4'b1110: alu_f = alu_a | alu_b;
            4'b1111: alu_f = alu_a;
            default: alu_f = alu_a & alu_b;
         endcase
      end else if (alu_s >= 4'b1000 && alu_s <= 4'b1011) begin
         alu_sum  = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, alu_cin};
         alu_f    = alu_sum[3:0];
         alu_cout = ~alu_sum[4];
      end else if (alu_s == 4'b1111) begin
         alu_sum  = {1'b0, alu_a} + 5'h0F + {4'b0, alu_cin};
         alu_f    = alu_sum[3:0];
         alu_cout = alu_sum[4];
      end else begin
         alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
         alu_f    = alu_sum[3:0];
         alu_cout = alu_sum[4];
      end
   end

   typedef struct {
      logic [15:0] a, b;
      logic [3:0]  s;
      logic        m, cin;
      logic [15:0] res;
      logic        cout, aeqb, zero, neg;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Present a request at the falling edge and let the next rising edge
   // accept it.
   task automatic start_op(input vec_t v, input string tag);
      @(negedge clk);
      in_valid = 1'b1;
      in_a = v.a; in_b = v.b; in_s = v.s; in_m = v.m; in_cin = v.cin;
      #1;
      chk({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk({tag, " in_ready in RUN"}, 32'(in_ready), 32'd0);
      chk({tag, " alu_cin nibble0"}, 32'(alu_cin), 32'(v.cin));
   endtask

   // Wait (bounded) for out_valid, check latency and results, then drain.
   task automatic finish_op(input vec_t v, input string tag);
      int lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'd4);
      chk({tag, " res"}, 32'(res), 32'(v.res));
      chk({tag, " c_out"}, 32'(c_out), 32'(v.cout));
      chk({tag, " a_eq_b"}, 32'(a_eq_b), 32'(v.aeqb));
`ifdef ULA_NIBBLE_SEQ_FLAGS_EN
      chk({tag, " zero"}, 32'(zero), 32'(v.zero));
      chk({tag, " neg"}, 32'(neg), 32'(v.neg));
`endif
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, " out_valid after drain"}, 32'(out_valid), 32'd0);
   endtask

   vec_t vecs[7];
   vec_t v;

   initial begin
      //         a        b        s        m     cin   res      cout  aeqb  zero  neg
      vecs[0] = '{16'h1234, 16'h0235, 4'b1000, 1'b0, 1'b1, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{16'hABCD, 16'hABCD, 4'b1111, 1'b1, 1'b0, 16'hABCD, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{16'hABCC, 16'hABCD, 4'b1111, 1'b1, 1'b0, 16'hABCC, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{16'h0000, 16'h0000, 4'b1111, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{16'hFFFF, 16'h0001, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{16'h0235, 16'h1234, 4'b1000, 1'b0, 1'b1, 16'hF001, 1'b1, 1'b0, 1'b0, 1'b1};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_s = '0; in_m = 1'b0; in_cin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset res", 32'(res), 32'd0);
      chk("reset c_out", 32'(c_out), 32'd0);
      chk("reset a_eq_b", 32'(a_eq_b), 32'd0);
      chk("reset alu_a/b/s", {20'd0, alu_a, alu_b, alu_s}, 32'd0);
      chk("reset alu_m/cin", {30'd0, alu_m, alu_cin}, 32'd0);
`ifdef ULA_NIBBLE_SEQ_FLAGS_EN
      chk("reset zero/neg", {30'd0, zero, neg}, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // ---- table-driven vectors ----
      for (int i = 0; i < 7; i++) begin
         start_op(vecs[i], $sformatf("vec%0d", i));
         finish_op(vecs[i], $sformatf("vec%0d", i));
      end

      // ---- DONE back-pressure with a pending request ----
      start_op(vecs[2], "stall");
      for (int w = 0; w < 20 && !out_valid; w++) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      v = vecs[0];
      in_valid = 1'b1;
      in_a = v.a; in_b = v.b; in_s = v.s; in_m = v.m; in_cin = v.cin;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("stall c%0d out_valid", c), 32'(out_valid), 32'd1);
         chk($sformatf("stall c%0d res", c), 32'(res), 32'hABCD);
         chk($sformatf("stall c%0d in_ready", c), 32'(in_ready), 32'd0);
         chk($sformatf("stall c%0d alu_a held", c), 32'(alu_a), 32'hD);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("release out_valid", 32'(out_valid), 32'd0);
      chk("release in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);            // pending request accepted here
      #1;
      in_valid = 1'b0;
      chk("pending in_ready in RUN", 32'(in_ready), 32'd0);
      finish_op(v, "pending");

      // ---- reset during RUN at k=2 ----
      start_op(vecs[5], "midrst");
      repeat (2) @(posedge clk);  // k = 2 after this
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst in_ready", 32'(in_ready), 32'd1);
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst res", 32'(res), 32'd0);
      chk("midrst alu_a/b/cin", {23'd0, alu_a, alu_b, alu_cin}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      start_op(vecs[6], "after_rst");
      finish_op(vecs[6], "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ula_nibble_seq.md
# ula_nibble_seq

Multi-nibble sequencer that runs wide (4·NIBBLES-bit) operations through the codebase's 4-bit ALU slice, one nibble per clock, least-significant nibble first. It sits directly around the ALU slice: upstream it drives the ALU's operand, function-select, mode and carry-in inputs; downstream it consumes the ALU's F, carry-out and A=B outputs and assembles them into a registered wide result. Operations enter and results leave through valid/ready handshakes.

## Interface
- NIBBLES, default 4: number of 4-bit slices; the data width is W = 4·NIBBLES.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_a, in_b  in  W  operands.
- in_s  in  4  ALU function select {S3..S0}.
- in_m  in  1  1 = logic mode, 0 = arithmetic mode.
- in_cin  in  1  carry-in for nibble 0.
- alu_a, alu_b  out  4  current nibble of the operands, driven to the ALU.
- alu_s  out  4  to the ALU.
- alu_m  out  1  to the ALU.
- alu_cin  out  1  to the ALU.
- alu_f  in  4  from the ALU.
- alu_cout  in  1  from the ALU.
- alu_aeqb  in  1  from the ALU.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed when out_valid && out_ready.
- res  out  W  assembled result.
- c_out  out  1  alu_cout of the last nibble, unmodified.
- a_eq_b  out  1  AND of alu_aeqb over all nibbles.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On handshake: capture in_a, in_b, in_s, in_m and in_cin; set k = 0; set the a_eq_b accumulator to 1; go to RUN.
- RUN:
  - in_ready = 0.
  - alu_a = a_reg[4k+:4]; alu_b = b_reg[4k+:4]; alu_s and alu_m come from the captured values; alu_cin = carry register.
  - Each RUN edge:
    - res[4k+:4] ← alu_f.
    - a_eq_b accumulator &= alu_aeqb.
    - Carry register ← next-carry.
    - k ← k+1.
  - Next-carry rule:
    - When m = 0 and s ∈ {1000, 1001, 1010, 1011}, next-carry = ~alu_cout. This restores the true carry, because the ALU reports the inverted carry for these codes.
    - Otherwise next-carry = alu_cout.
  - At k = NIBBLES−1, the same edge also latches c_out ← alu_cout (raw) and a_eq_b, then goes to DONE.
- DONE:
  - out_valid = 1.
  - res, c_out and a_eq_b are held stable.
  - in_valid is ignored.
  - On out_ready: go to IDLE.
- Wide-result semantics follow the per-nibble ALU semantics exactly. Function codes whose ALU result ignores carry-in do not propagate carry between nibbles; this is intended.
- k counter width is $clog2(NIBBLES), with a minimum of 1 bit. k never exceeds NIBBLES−1.

## Timing
- Reset, which takes priority from any state including mid-RUN:
  - State goes to IDLE; the in-flight operation is discarded.
  - res = 0, c_out = 0, a_eq_b = 0, out_valid = 0, in_ready = 1.
  - Captured registers, k and carry are cleared, so alu_a = alu_b = alu_s = 0, alu_m = 0 and alu_cin = 0.
- Latency: out_valid rises exactly NIBBLES cycles after the accepting edge.
- Minimum issue interval is NIBBLES+2 cycles: RUN×NIBBLES, DONE×1 and IDLE×1. There is no back-to-back accept from DONE.
- in_ready and out_valid are decoded directly from state registers, with no combinational path from any input.
- The ALU slice is purely combinational. alu_* outputs are registers; the alu_f/alu_cout → res/carry path is one combinational hop within a cycle.
- In IDLE, alu_* hold the last captured values (zeros after reset). No value carried over from the previous operation is valid.

## Configuration
- ULA_NIBBLE_SEQ_FLAGS_EN defined:
  - Adds outputs zero (res == 0) and neg (res[W−1]).
  - Both are registered on the same edge as the final nibble, reset to 0, and held through DONE.
- Not defined: the ports and their logic are absent; all other behaviour is identical.

## Structure
- Shared package ula_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t.
  - localparam NIB_W = 4.
  - Constants S_SUB_LO = 4'b1000 and S_SUB_HI = 4'b1011, which bound the carry-inversion range.
- No sub-module: the ALU slice stays external and is wired by the parent.

## Test plan
(NIBBLES = 4, with a reference ALU slice attached.)
- m=0, s=1000, cin=1, A=0x1234, B=0x0235 → res=0x0FFF, c_out=0, out_valid exactly 4 cycles after accept.
- m=1, s=0110, A=0xF0F0, B=0xFF00 → res=0x0FF0, c_out=0, a_eq_b=0.
- m=1, s=1111, A=B=0xABCD → res=0xABCD, a_eq_b=1; with A=0xABCC → a_eq_b=0.
- m=0, s=1111, cin=0, A=0x0000 → res=0xFFFF, c_out=0; with FLAGS_EN: zero=0, neg=1.
- out_ready held low 5 cycles in DONE while in_valid=1 → out_valid=1, res stable, in_ready=0, no capture; release → IDLE, then the pending request is accepted.
- rst pulsed during RUN at k=2 → next cycle IDLE, out_valid=0, res=0, in_ready=1; the following operation completes correctly.
